serial_frame_receiver: RTL

Receive-side deserializer for the serial transceiver's output stream. It samples `DataOut` on rising edges of `ClkTx` while `DOutValid` is high and rebuilds 32-bit frames, MSB first. Completed frames go into a small first-word-fall-through FIFO. It also decodes the head word into the concatenator fields (operand A, operand B, ALU result, select, flags). The block sits directly downstream of the serial transceiver, in the same `Clk` domain as the frequency divider that generates `ClkTx`.

---
 rtl/serial_frame_receiver_pkg.sv | 20 ++
 rtl/serial_frame_receiver_if.sv | 30 +++
 rtl/serial_frame_receiver_fifo.sv | 57 +++++
 rtl/serial_frame_receiver.sv | 116 +++++++++++
 4 files changed

// File: rtl/serial_frame_receiver_pkg.sv
// Shared types and constants for the serial frame receiver.
package serial_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PUSH  = 2'd2
    } rx_state_t;

    // Head-word field MSB positions (32-bit frame)
    localparam int A_MSB   = 31;
    localparam int B_MSB   = 23;
    localparam int RES_MSB = 15;
    localparam int SEL_MSB = 7;
    localparam int FLG_MSB = 3;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Serial input, FIFO read port and status/decode outputs of the receiver.
interface serial_frame_receiver_if #(parameter int WIDTH = 32);
    logic             ClkTx;
    logic             DOutValid;
    logic             DataOut;
    logic             RdEn;
    logic [WIDTH-1:0] RdData;
    logic             Empty;
    logic             Full;
    logic             Overflow;
    logic             FrameError;
    logic [7:0]       FrameCount;
    logic [7:0]       HeadA;
    logic [7:0]       HeadB;
    logic [7:0]       HeadResult;
    logic [3:0]       HeadSel;
    logic [3:0]       HeadFlags;

    modport master (
        output ClkTx, DOutValid, DataOut, RdEn,
        input  RdData, Empty, Full, Overflow, FrameError, FrameCount,
               HeadA, HeadB, HeadResult, HeadSel, HeadFlags
    );

    modport slave (
        input  ClkTx, DOutValid, DataOut, RdEn,
        output RdData, Empty, Full, Overflow, FrameError, FrameCount,
               HeadA, HeadB, HeadResult, HeadSel, HeadFlags
    );
endinterface

// File: rtl/serial_frame_receiver_fifo.sv
// First-word-fall-through FIFO holding completed frames.
module rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // a push into a full FIFO only lands when the head leaves the same cycle
    assign do_push = push_i & (~full_o | do_pop);
    // head reads as zero when nothing is stored
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    // occupancy next-state
    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // pointers and occupancy; pointers wrap naturally modulo DEPTH
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // storage array; contents are don't-care until pointed at
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end
endmodule

// File: rtl/serial_frame_receiver.sv
// Deserializes the transceiver bit stream into 32-bit frames, queues them
// and decodes the head word into concatenator fields.
module serial_frame_receiver
    import serial_rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic Clk,
    input  logic Reset,
    serial_frame_receiver_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    rx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       fcnt_q, fcnt_d;
    logic             clktx_q, ovf_q, ovf_d, ferr_q, ferr_d;
    logic             rise, accept, pop, push, full, empty;
    logic [WIDTH-1:0] rd_data;

    assign rise   = bus.ClkTx & ~clktx_q;
    assign accept = rise & bus.DOutValid;
    assign pop    = bus.RdEn & ~empty;

    // frame assembly FSM: next state, shift/count updates, push decision
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        ovf_d   = ovf_q;
        ferr_d  = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = {shreg_q[WIDTH-2:0], bus.DataOut};
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!bus.DOutValid) begin
                    // transmitter abandoned the frame; drop the partial word
                    state_d = IDLE;
                    cnt_d   = '0;
                    ferr_d  = 1'b1;
                end else if (accept) begin
                    shreg_d = {shreg_q[WIDTH-2:0], bus.DataOut};
                    if (cnt_q == CW'(WIDTH-1)) begin
                        state_d = PUSH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PUSH: begin
                state_d = IDLE;
                if (!full || pop) begin
                    push   = 1'b1;
                    fcnt_d = fcnt_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state, datapath and status registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            clktx_q <= 1'b0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            clktx_q <= bus.ClkTx;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
        end
    end

    rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (shreg_q),
        .rdata_o (rd_data),
        .empty_o (empty),
        .full_o  (full)
    );

    assign bus.RdData     = rd_data;
    assign bus.Empty      = empty;
    assign bus.Full       = full;
    assign bus.Overflow   = ovf_q;
    assign bus.FrameError = ferr_q;
    assign bus.FrameCount = fcnt_q;
    assign bus.HeadA      = rd_data[A_MSB   -: 8];
    assign bus.HeadB      = rd_data[B_MSB   -: 8];
    assign bus.HeadResult = rd_data[RES_MSB -: 8];
    assign bus.HeadSel    = rd_data[SEL_MSB -: 4];
    assign bus.HeadFlags  = rd_data[FLG_MSB -: 4];
endmodule
